// File: rtl/spart_pkg.sv
// spart_pkg: shared bus addresses, FSM state encodings and baud divisor lookup
// for the SPART echo controller.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    localparam logic [15:0] DIV_4800  = 16'd10416;
    localparam logic [15:0] DIV_9600  = 16'd5208;
    localparam logic [15:0] DIV_19200 = 16'd2604;
    localparam logic [15:0] DIV_38400 = 16'd1302;

    localparam logic [2:0] S_CFG_LO = 3'd0;
    localparam logic [2:0] S_CFG_HI = 3'd1;
    localparam logic [2:0] S_IDLE   = 3'd2;
    localparam logic [2:0] S_RD     = 3'd3;
    localparam logic [2:0] S_RD_GAP = 3'd4;
    localparam logic [2:0] S_WR     = 3'd5;
    localparam logic [2:0] S_WR_GAP = 3'd6;

    // Divisor table is passed in so a top-level parameter override still applies.
    function automatic logic [15:0] div_sel(
        input logic [1:0]  br_cfg,
        input logic [15:0] d0 = DIV_4800,
        input logic [15:0] d1 = DIV_9600,
        input logic [15:0] d2 = DIV_19200,
        input logic [15:0] d3 = DIV_38400
    );
        return br_cfg == 2'b00 ? d0 : br_cfg == 2'b01 ? d1 : br_cfg == 2'b10 ? d2 : d3;
    endfunction

endpackage

// File: rtl/spart_byte_fifo.sv
// spart_byte_fifo: DEPTH x 8 synchronous FIFO holding received bytes until echoed.
// Ports: clk, rst (sync active-low), push/din write side, pop/head read side,
// full/empty flags, count of stored bytes. Push when full and pop when empty are ignored.
module spart_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          push_ok;
    logic          pop_ok;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rp];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push_ok) wp <= wp + AW'(1);
            if (pop_ok) rp <= rp + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/spart_echo_ctrl.sv
// spart_echo_ctrl: sole bus master for one SPART; programs the baud divisor, then echoes
// every received byte back out through a small FIFO.
// Ports: clk, rst (sync active-low), br_cfg baud select, rda/tbr SPART status,
// iocs/iorw/ioaddr/databus bus access, cfg_done divisor programmed, fifo_count bytes queued.
module spart_echo_ctrl
    import spart_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] DIV_4800  = 16'd10416,
    parameter logic [15:0] DIV_9600  = 16'd5208,
    parameter logic [15:0] DIV_19200 = 16'd2604,
    parameter logic [15:0] DIV_38400 = 16'd1302
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               br_cfg,
    input  logic                     rda,
    input  logic                     tbr,
    output logic                     iocs,
    output logic                     iorw,
    output logic [1:0]               ioaddr,
    inout  wire  [7:0]               databus,
    output logic                     cfg_done,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    logic [2:0]  state;
    logic [1:0]  cfg_q;
    logic        run;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        drive;
    logic [7:0]  head;
    logic [7:0]  dout;
    logic [15:0] div;

    // run is low for the reset cycle itself, so the bus stays quiet while rst is held
    // even though state already sits at CFG_LO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_CFG_LO;
            cfg_q    <= br_cfg;
            cfg_done <= 1'b0;
            run      <= 1'b0;
        end else begin
            run <= 1'b1;
            if (run) begin
                case (state)
                    S_CFG_LO: state <= S_CFG_HI;
                    S_CFG_HI: begin
                        state    <= S_IDLE;
                        cfg_done <= 1'b1;
                    end
                    S_IDLE: begin
                        if (br_cfg != cfg_q) begin
                            cfg_q    <= br_cfg;
                            cfg_done <= 1'b0;
                            state    <= S_CFG_LO;
                        end else if (rda && !full) begin
                            state <= S_RD;
                        end else if (tbr && !empty) begin
                            state <= S_WR;
                        end
                    end
                    S_RD:    state <= S_RD_GAP;
                    S_WR:    state <= S_WR_GAP;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign div    = div_sel(cfg_q, DIV_4800, DIV_9600, DIV_19200, DIV_38400);
    assign iocs   = run && (state == S_CFG_LO || state == S_CFG_HI || state == S_RD || state == S_WR);
    assign iorw   = !(iocs && state != S_RD);
    assign ioaddr = (run && state == S_CFG_LO) ? ADDR_DBL :
                    (run && state == S_CFG_HI) ? ADDR_DBH : ADDR_DATA;
    assign push   = run && state == S_RD;
    assign pop    = run && state == S_WR;
    assign drive  = iocs && !iorw;
    assign dout   = state == S_CFG_LO ? div[7:0] : state == S_CFG_HI ? div[15:8] : head;
    assign databus = drive ? dout : 8'hzz;

    spart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (databus),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_spart_echo_ctrl.sv
// tb_spart_echo_ctrl: scoreboard bench for spart_echo_ctrl with a simple SPART register model.
module tb_spart_echo_ctrl;

    typedef struct packed {
        logic       rw;
        logic [1:0] a;
        logic [7:0] d;
    } acc_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] br_cfg = 2'b10;
    logic       tbr_en = 1'b0;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       cfg_done;
    logic [2:0] fifo_count;
    logic       rda;
    logic       sp_rd;

    logic [7:0] rx_mem [16];
    int         rx_wr = 0;
    int         rx_rd = 0;

    acc_t exp_q[$];
    acc_t m_act;
    acc_t m_exp;
    int   n_cmp = 0;
    int   n_bad = 0;

    spart_echo_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .rda        (rda),
        .tbr        (tbr_en),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .databus    (databus),
        .cfg_done   (cfg_done),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    assign rda     = rx_wr != rx_rd;
    assign sp_rd   = iocs && iorw && ioaddr == 2'b00;
    assign databus = sp_rd ? rx_mem[rx_rd[3:0]] : 8'hzz;

    always @(posedge clk) if (sp_rd) rx_rd <= rx_rd + 1;

    always @(negedge clk) begin
        if (iocs) begin
            m_act = {iorw, ioaddr, iorw ? 8'h00 : databus};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL bus_access: got rw=%0b addr=%0d data=%02h, required no access", iorw, ioaddr, m_act.d);
            end else begin
                m_exp = exp_q.pop_front();
                if (m_act !== m_exp) begin
                    n_bad++;
                    $display("FAIL bus_access: got rw=%0b addr=%0d data=%02h, required rw=%0b addr=%0d data=%02h",
                             m_act.rw, m_act.a, m_act.d, m_exp.rw, m_exp.a, m_exp.d);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic ew(input logic [1:0] a, input logic [7:0] d);
        exp_q.push_back({1'b0, a, d});
    endtask

    task automatic er();
        exp_q.push_back({1'b1, 2'b00, 8'h00});
    endtask

    task automatic send(input logic [7:0] b);
        rx_mem[rx_wr[3:0]] = b;
        rx_wr++;
    endtask

    task automatic drain(input string nm);
        int i = 0;
        while (exp_q.size() != 0 && i < 400) begin
            @(negedge clk);
            i++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d accesses outstanding required 0", nm, exp_q.size());
            exp_q.delete();
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int i;
        repeat (3) @(negedge clk);
        chk("rst_iocs", iocs, 0);
        chk("rst_iorw", iorw, 1);
        chk("rst_ioaddr", ioaddr, 0);
        chk("rst_cfg_done", cfg_done, 0);
        chk("rst_fifo_count", fifo_count, 0);

        ew(2'b10, 8'h2C);
        ew(2'b11, 8'h0A);
        rst = 1'b1;
        @(negedge clk);
        chk("cfg_done_lo", cfg_done, 0);
        @(negedge clk);
        chk("cfg_done_hi", cfg_done, 0);
        @(negedge clk);
        chk("cfg_done_after", cfg_done, 1);
        drain("cfg19200");

        tbr_en = 1'b1;
        er();
        ew(2'b00, 8'hA5);
        send(8'hA5);
        drain("echo_a5");
        chk("a5_fifo_count", fifo_count, 0);

        tbr_en = 1'b0;
        repeat (4) er();
        send(8'hE7); send(8'h24); send(8'h11); send(8'h22); send(8'h33);
        drain("fill");
        chk("full_fifo_count", fifo_count, 4);
        chk("full_pending", rx_wr - rx_rd, 1);

        ew(2'b00, 8'hE7);
        er();
        ew(2'b00, 8'h24);
        ew(2'b00, 8'h11);
        ew(2'b00, 8'h22);
        ew(2'b00, 8'h33);
        tbr_en = 1'b1;
        drain("flush");
        chk("flush_fifo_count", fifo_count, 0);
        chk("flush_pending", rx_wr - rx_rd, 0);

        ew(2'b10, 8'h16);
        ew(2'b11, 8'h05);
        br_cfg = 2'b11;
        @(negedge clk);
        chk("recfg_cfg_done_low", cfg_done, 0);
        drain("cfg38400");
        chk("recfg_cfg_done", cfg_done, 1);
        er();
        ew(2'b00, 8'h5A);
        send(8'h5A);
        drain("echo_5a");

        tbr_en = 1'b0;
        er();
        send(8'h77);
        drain("hold_77");
        chk("hold_fifo_count", fifo_count, 1);
        ew(2'b00, 8'h77);
        tbr_en = 1'b1;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!(iocs && !iorw) && i < 50);
        chk("wr_seen", iocs && !iorw, 1);
        rst = 1'b0;
        tbr_en = 1'b0;
        ew(2'b10, 8'h16);
        ew(2'b11, 8'h05);
        @(negedge clk);
        chk("midrst_iocs", iocs, 0);
        chk("midrst_iorw", iorw, 1);
        chk("midrst_fifo_count", fifo_count, 0);
        chk("midrst_cfg_done", cfg_done, 0);
        rst = 1'b1;
        drain("reprogram");
        chk("reprogram_cfg_done", cfg_done, 1);
        chk("reprogram_fifo_count", fifo_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
